// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory load/store unit: access-type codes,
// FSM state encoding, and the size/extension helpers.
package dm_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        A1   = 2'd1,
        A2   = 2'd2,
        RESP = 2'd3
    } dm_state_e;

    // Access size in bytes; 0 marks an invalid type code.
    function automatic logic [2:0] dm_size(input logic [2:0] t);
        case (t)
            DM_WORD:              dm_size = 3'd4;
            DM_HALF, DM_HALF_U:   dm_size = 3'd2;
            DM_BYTE, DM_BYTE_U:   dm_size = 3'd1;
            default:              dm_size = 3'd0;
        endcase
    endfunction

    // Masks the right-justified load value to its size and sign/zero extends it.
    function automatic logic [31:0] dm_extend(input logic [31:0] d, input logic [2:0] t);
        case (t)
            DM_HALF:   dm_extend = {{16{d[15]}}, d[15:0]};
            DM_HALF_U: dm_extend = {16'h0000, d[15:0]};
            DM_BYTE:   dm_extend = {{24{d[7]}}, d[7:0]};
            DM_BYTE_U: dm_extend = {24'h000000, d[7:0]};
            default:   dm_extend = d;
        endcase
    endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// Request/response bundle between the MEM stage (master) and the LSU (slave).
// A transfer happens on a rising edge where valid & ready are both high; the
// sender keeps valid and its payload stable until then, and ready never waits on a later valid.
interface dm_lsu_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        req_type;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_type, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_type, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_bank.sv
// Single-port word RAM with byte-enable writes and a one-cycle registered read.
// The read port returns the freshly written bytes when read and write hit the same word.
module dm_bank #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = 6
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    always_comb begin
        rdata_d = mem[addr];
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                rdata_d[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= rdata_d;
            end
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/dm_lsu.sv
// Load/store front end for the data bank: validates requests, splits word-crossing
// accesses into two bank cycles and returns extended load data through a held response.
module dm_lsu
    import dm_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DEPTH_WORDS = 64,
    parameter int MISALIGN_EN = 1
) (
    input  logic      clk,
    input  logic      rstn,
    dm_lsu_if.slave   bus,
    output dm_state_e dbg_state
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int LW = ADDR_W + 1;
    localparam logic [LW-1:0] DEPTH_BYTES = LW'(4 * DEPTH_WORDS);

    dm_state_e   state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  type_q, type_d;
    logic [1:0]  off_q, off_d;
    logic        split_q, split_d;
    logic [AW-1:0] w1_q, w1_d;
    logic [3:0]  be1_q, be1_d;
    logic [31:0] wdata1_q, wdata1_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic          bank_en, bank_we;
    logic [AW-1:0] bank_addr;
    logic [3:0]    bank_be;
    logic [31:0]   bank_wdata, bank_rdata;

    logic [2:0]    req_n;
    logic [1:0]    req_off;
    logic [AW-1:0] req_w0;
    logic [LW-1:0] req_last;
    logic          req_mis, req_err, req_split;
    logic [3:0]    size_mask;
    logic [7:0]    be_all;
    logic [63:0]   wd_all;
    logic [31:0]   asm_word;
    logic          accept;

    // Lane placement spans two words: the low half goes to w0, the spill-over to w0+1.
    always_comb begin
        req_n     = dm_size(bus.req_type);
        req_off   = bus.req_addr[1:0];
        req_w0    = AW'(bus.req_addr >> 2);
        req_last  = {1'b0, bus.req_addr} + LW'(req_n) - LW'(1);
        req_mis   = ((req_n == 3'd2) && req_off[0]) || ((req_n == 3'd4) && (req_off != 2'd0));
        req_err   = (req_n == 3'd0) || (req_last >= DEPTH_BYTES) || ((MISALIGN_EN == 0) && req_mis);
        req_split = ({1'b0, req_off} + req_n) > 3'd4;
        size_mask = (req_n == 3'd4) ? 4'hf : (req_n == 3'd2) ? 4'h3 : 4'h1;
        be_all    = {4'h0, size_mask} << req_off;
        wd_all    = {32'h0, bus.req_wdata} << {req_off, 3'b000};
    end

    assign bus.req_ready = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        type_d     = type_q;
        off_d      = off_q;
        split_d    = split_q;
        w1_d       = w1_q;
        be1_d      = be1_q;
        wdata1_d   = wdata1_q;
        hold_d     = hold_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        bank_en    = 1'b0;
        bank_we    = 1'b0;
        bank_addr  = req_w0;
        bank_be    = be_all[3:0];
        bank_wdata = wd_all[31:0];
        asm_word   = '0;

        case (state_q)
            A1: begin
                hold_d = bank_rdata;
                if (split_q) begin
                    bank_en    = 1'b1;
                    bank_we    = we_q;
                    bank_addr  = w1_q;
                    bank_be    = be1_q;
                    bank_wdata = wdata1_q;
                    state_d    = A2;
                end else begin
                    asm_word = bank_rdata >> {off_q, 3'b000};
                    rdata_d  = we_q ? 32'h0 : dm_extend(asm_word, type_q);
                    err_d    = 1'b0;
                    state_d  = RESP;
                end
            end
            A2: begin
                asm_word = 32'({bank_rdata, hold_q} >> {off_q, 3'b000});
                rdata_d  = we_q ? 32'h0 : dm_extend(asm_word, type_q);
                err_d    = 1'b0;
                state_d  = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // Accept only happens in IDLE/RESP, so it never competes with A1 for the bank.
        if (accept) begin
            we_d     = bus.req_we;
            type_d   = bus.req_type;
            off_d    = req_off;
            split_d  = req_split;
            w1_d     = req_w0 + AW'(1);
            be1_d    = be_all[7:4];
            wdata1_d = wd_all[63:32];
            if (req_err) begin
                state_d = RESP;
                err_d   = 1'b1;
                rdata_d = 32'h0;
            end else begin
                state_d = A1;
                bank_en = 1'b1;
                bank_we = bus.req_we;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            type_q   <= 3'b000;
            off_q    <= 2'b00;
            split_q  <= 1'b0;
            w1_q     <= '0;
            be1_q    <= 4'h0;
            wdata1_q <= 32'h0;
            hold_q   <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            type_q   <= type_d;
            off_q    <= off_d;
            split_q  <= split_d;
            w1_q     <= w1_d;
            be1_q    <= be1_d;
            wdata1_q <= wdata1_d;
            hold_q   <= hold_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    dm_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_bank (
        .clk  (clk),
        .en   (bank_en),
        .we   (bank_we),
        .addr (bank_addr),
        .be   (bank_be),
        .wdata(bank_wdata),
        .rdata(bank_rdata)
    );

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_dm_lsu.sv
// Randomised and directed checks of dm_lsu against a byte-array memory model;
// one instance splits misaligned accesses, a second one rejects them.
module tb_dm_lsu;
    import dm_pkg::*;

    localparam int DB = 256;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dm_lsu_if #(.ADDR_W(8)) b1();
    dm_lsu_if #(.ADDR_W(8)) b2();
    dm_state_e st1, st2;

    dm_lsu #(.ADDR_W(8), .DEPTH_WORDS(64), .MISALIGN_EN(1)) dut1 (
        .clk(clk), .rstn(rstn), .bus(b1.slave), .dbg_state(st1));
    dm_lsu #(.ADDR_W(8), .DEPTH_WORDS(64), .MISALIGN_EN(0)) dut2 (
        .clk(clk), .rstn(rstn), .bus(b2.slave), .dbg_state(st2));

    typedef struct {
        int          acc;
        int          lat;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mem1 [DB];
    logic [7:0]  mem2 [DB];
    int          cyc = 0;
    int          vec = 0;
    int          bad = 0;
    int          rdy_mode = 0;
    bit          chk_en = 1'b1;
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;
    int          hs_edge;
    bit          head_seen = 1'b0;
    int          head_lat = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference behaviour: byte-addressed memory, response value and T+k valid cycle.
    function automatic void model(input bit mis, input logic we, input logic [7:0] addr,
                                  input logic [31:0] wd, input logic [2:0] ty,
                                  output logic err, output logic [31:0] rd, output int lat);
        int n;
        int a;
        logic [31:0] v;
        n = (ty == 3'd0) ? 4 : (ty == 3'd1 || ty == 3'd2) ? 2 : (ty == 3'd3 || ty == 3'd4) ? 1 : 0;
        a = int'(addr);
        err = (n == 0) || (a + n - 1 >= DB) || (!mis && n != 0 && (a % n) != 0);
        rd = 32'h0;
        lat = 1;
        if (err) return;
        lat = ((a % 4) + n > 4) ? 3 : 2;
        if (we) begin
            for (int i = 0; i < n; i++) begin
                if (mis) mem1[a + i] = wd[8*i +: 8];
                else     mem2[a + i] = wd[8*i +: 8];
            end
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mis ? mem1[a + i] : mem2[a + i];
            if ((ty == 3'd1 || ty == 3'd3) && v[8*n - 1]) v = v | (32'hffffffff << (8 * n));
            rd = v;
        end
    endfunction

    initial begin
        b1.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            b1.rsp_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
        end
    end

    // Per-cycle comparison of dut1 against the head of the expected queue.
    always @(negedge clk) begin : compare
        bit head_live;
        bit v_exp;
        bit r_exp;
        if (rstn && chk_en) begin
            head_live = (exp_q.size() > 0) && (exp_q[0].acc <= cyc);
            v_exp = head_live && (cyc - exp_q[0].acc + 1 >= exp_q[0].lat);
            r_exp = !head_live || (v_exp && b1.rsp_ready);
            chk("rsp_valid", 32'(b1.rsp_valid), 32'(v_exp));
            chk("req_ready", 32'(b1.req_ready), 32'(r_exp));
            if (head_live && b1.rsp_valid && !head_seen) begin
                head_seen = 1'b1;
                head_lat = cyc - exp_q[0].acc + 1;
            end
            if (v_exp) begin
                chk("rsp_rdata", b1.rsp_rdata, exp_q[0].rdata);
                chk("rsp_err", 32'(b1.rsp_err), 32'(exp_q[0].err));
                if (b1.rsp_ready) begin
                    last_rdata = b1.rsp_rdata;
                    last_err = b1.rsp_err;
                    last_lat = head_lat;
                    hs_edge = cyc + 1;
                    head_seen = 1'b0;
                    head_lat = -1;
                    void'(exp_q.pop_front());
                end
            end else if (head_live && (cyc - exp_q[0].acc > 100)) begin
                vec++;
                bad++;
                $display("FAIL rsp_stall: no response after %0d cycles", cyc - exp_q[0].acc);
                head_seen = 1'b0;
                void'(exp_q.pop_front());
            end
        end
    end

    // Must be called at a falling edge; returns the edge index on which the request was taken.
    task automatic issue(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                         input logic [2:0] ty, output int acc);
        int g;
        exp_t e;
        b1.req_valid = 1'b1;
        b1.req_we = we;
        b1.req_addr = addr;
        b1.req_wdata = wd;
        b1.req_type = ty;
        g = 0;
        while (!b1.req_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!b1.req_ready) begin
            vec++;
            bad++;
            $display("FAIL accept_timeout: req_ready stuck low");
            b1.req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        e.acc = acc;
        model(1'b1, we, addr, wd, ty, e.err, e.rdata, e.lat);
        exp_q.push_back(e);
        @(negedge clk);
        b1.req_valid = 1'b0;
        b1.req_we = 1'($urandom);
        b1.req_addr = 8'($urandom);
        b1.req_wdata = $urandom;
        b1.req_type = 3'($urandom);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            vec++;
            bad++;
            $display("FAIL idle_timeout: %0d responses outstanding", exp_q.size());
        end
    endtask

    task automatic req2(input logic we, input logic [7:0] a, input logic [31:0] wd,
                        input logic [2:0] ty, output logic [31:0] rd, output logic er, output int lat);
        int g;
        int acc;
        b2.req_valid = 1'b1;
        b2.req_we = we;
        b2.req_addr = a;
        b2.req_wdata = wd;
        b2.req_type = ty;
        g = 0;
        while (!b2.req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        acc = cyc + 1;
        @(negedge clk);
        b2.req_valid = 1'b0;
        g = 0;
        while (!b2.rsp_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        lat = b2.rsp_valid ? (cyc - acc + 1) : -1;
        rd = b2.rsp_rdata;
        er = b2.rsp_err;
        @(negedge clk);
    endtask

    task automatic check2(input string nm, input logic we, input logic [7:0] a,
                          input logic [31:0] wd, input logic [2:0] ty,
                          output logic [31:0] rd, output logic er);
        logic [31:0] m_rd;
        logic m_er;
        int m_lat;
        int lat;
        model(1'b0, we, a, wd, ty, m_er, m_rd, m_lat);
        req2(we, a, wd, ty, rd, er, lat);
        chk({nm, "_rdata"}, rd, m_rd);
        chk({nm, "_err"}, 32'(er), 32'(m_er));
        chk({nm, "_lat"}, 32'(lat), 32'(m_lat));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int acc;
        int acc_b;
        int hs_a;
        logic [31:0] rd;
        logic er;
        logic [2:0] ty;
        logic [7:0] addr;
        int sel;

        b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = 8'h0; b1.req_wdata = 32'h0; b1.req_type = 3'h0;
        b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_addr = 8'h0; b2.req_wdata = 32'h0; b2.req_type = 3'h0;
        b2.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", 32'(b1.rsp_valid), 32'h0);
        chk("reset_rsp_rdata", b1.rsp_rdata, 32'h0);
        chk("reset_rsp_err", 32'(b1.rsp_err), 32'h0);
        chk("reset_state", 32'(st1), 32'(IDLE));
        chk("reset_rsp_valid2", 32'(b2.rsp_valid), 32'h0);
        rstn = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", 32'(b1.req_ready), 32'h1);

        for (int w = 0; w < 64; w++) issue(1'b1, 8'(4 * w), $urandom, DM_WORD, acc);
        wait_idle();

        issue(1'b1, 8'h10, 32'h8badf00d, DM_WORD, acc);
        issue(1'b0, 8'h10, 32'h0, DM_WORD, acc);
        wait_idle();
        chk("aligned_rdata", last_rdata, 32'h8badf00d);
        chk("aligned_err", 32'(last_err), 32'h0);
        chk("aligned_latency", 32'(last_lat), 32'd2);

        issue(1'b1, 8'h20, 32'h0, DM_BYTE, acc);
        issue(1'b1, 8'h21, 32'h80, DM_BYTE, acc);
        issue(1'b0, 8'h21, 32'h0, DM_BYTE, acc);
        wait_idle();
        chk("lb_signed", last_rdata, 32'hffffff80);
        issue(1'b0, 8'h21, 32'h0, DM_BYTE_U, acc);
        wait_idle();
        chk("lb_unsigned", last_rdata, 32'h00000080);
        issue(1'b0, 8'h20, 32'h0, DM_HALF_U, acc);
        wait_idle();
        chk("lh_unsigned", last_rdata, 32'h00008000);

        issue(1'b1, 8'h0c, 32'ha0a1a2a3, DM_WORD, acc);
        issue(1'b1, 8'h10, 32'hb0b1b2b3, DM_WORD, acc);
        issue(1'b1, 8'h0e, 32'h11223344, DM_WORD, acc);
        issue(1'b0, 8'h0e, 32'h0, DM_WORD, acc);
        wait_idle();
        chk("split_rdata", last_rdata, 32'h11223344);
        chk("split_latency", 32'(last_lat), 32'd3);
        issue(1'b0, 8'h0c, 32'h0, DM_WORD, acc);
        wait_idle();
        chk("split_word0", last_rdata, 32'h3344a2a3);
        issue(1'b0, 8'h10, 32'h0, DM_WORD, acc);
        wait_idle();
        chk("split_word1", last_rdata, 32'hb0b11122);

        issue(1'b0, 8'hfe, 32'h0, DM_WORD, acc);
        wait_idle();
        chk("range_err", 32'(last_err), 32'h1);
        chk("range_rdata", last_rdata, 32'h0);
        chk("range_latency", 32'(last_lat), 32'd1);
        issue(1'b0, 8'h10, 32'h0, 3'b101, acc);
        wait_idle();
        chk("type_err", 32'(last_err), 32'h1);

        rdy_mode = 2;
        issue(1'b0, 8'h10, 32'h0, DM_WORD, acc);
        repeat (6) @(negedge clk);
        chk("bp_req_ready", 32'(b1.req_ready), 32'h0);
        chk("bp_rsp_valid", 32'(b1.rsp_valid), 32'h1);
        rdy_mode = 0;
        issue(1'b0, 8'h0c, 32'h0, DM_WORD, acc_b);
        hs_a = hs_edge;
        wait_idle();
        chk("same_cycle_accept", 32'(acc_b), 32'(hs_a));

        rdy_mode = 1;
        for (int k = 0; k < 400; k++) begin
            sel = $urandom_range(0, 15);
            ty = (sel < 2) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            addr = (sel == 15) ? 8'($urandom_range(248, 255)) : 8'($urandom_range(0, 255));
            issue(1'($urandom), addr, $urandom, ty, acc);
        end
        rdy_mode = 0;
        @(negedge clk);
        wait_idle();

        chk_en = 1'b0;
        rdy_mode = 2;
        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_addr = 8'h00; b1.req_type = DM_WORD;
        @(negedge clk);
        b1.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_resp_valid_before", 32'(b1.rsp_valid), 32'h1);
        rstn = 1'b0;
        #1;
        chk("rst_resp_valid_after", 32'(b1.rsp_valid), 32'h0);
        chk("rst_resp_rdata_after", b1.rsp_rdata, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        rdy_mode = 0;
        @(negedge clk);
        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_addr = 8'h1e;
        b1.req_wdata = 32'h55667788; b1.req_type = DM_WORD;
        chk("rst_split_ready", 32'(b1.req_ready), 32'h1);
        @(negedge clk);
        b1.req_valid = 1'b0;
        chk("rst_split_in_a1", 32'(st1), 32'(A1));
        rstn = 1'b0;
        #1;
        chk("rst_split_valid", 32'(b1.rsp_valid), 32'h0);
        chk("rst_split_state", 32'(st1), 32'(IDLE));
        mem1[8'h1e] = 8'h88;
        mem1[8'h1f] = 8'h77;
        exp_q.delete();
        head_seen = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", 32'(b1.req_ready), 32'h1);
        chk_en = 1'b1;
        issue(1'b0, 8'h1c, 32'h0, DM_WORD, acc);
        wait_idle();
        chk("rst_w0_written", 32'(last_rdata[31:16]), 32'h7788);
        issue(1'b0, 8'h20, 32'h0, DM_WORD, acc);
        wait_idle();

        check2("m0_init0", 1'b1, 8'h00, 32'h01020304, DM_WORD, rd, er);
        check2("m0_init1", 1'b1, 8'h04, 32'h05060708, DM_WORD, rd, er);
        check2("m0_sh_mis", 1'b1, 8'h03, 32'h0000beef, DM_HALF, rd, er);
        chk("m0_sh_mis_lit", 32'(er), 32'h1);
        check2("m0_nowrite", 1'b0, 8'h00, 32'h0, DM_WORD, rd, er);
        chk("m0_nowrite_lit", rd, 32'h01020304);
        check2("m0_lh_mis", 1'b0, 8'h03, 32'h0, DM_HALF, rd, er);
        chk("m0_lh_mis_lit", 32'(er), 32'h1);
        check2("m0_lh", 1'b0, 8'h02, 32'h0, DM_HALF, rd, er);
        chk("m0_lh_lit", rd, 32'h00000102);
        check2("m0_lw_mis", 1'b0, 8'h02, 32'h0, DM_WORD, rd, er);
        check2("m0_lbu", 1'b0, 8'h07, 32'h0, DM_BYTE_U, rd, er);
        chk("m0_lbu_lit", rd, 32'h00000005);
        check2("m0_sh", 1'b1, 8'h06, 32'h00008001, DM_HALF_U, rd, er);
        check2("m0_lhs", 1'b0, 8'h06, 32'h0, DM_HALF, rd, er);
        chk("m0_lhs_lit", rd, 32'hffff8001);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
